// File: rtl/alu_exec_pipe.sv
// Execute-stage wrapper around the 16-bit alu: an issue slot feeds the alu, a result slot
// captures its outputs for writeback, and a saturating counter tallies overflowed results.
module alu_exec_pipe #(
    parameter int DW    = 16,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DW-1:0]    in_A,
    input  logic [DW-1:0]    in_B,
    input  logic             in_Cin,
    input  logic [2:0]       in_Op,
    input  logic             in_invA,
    input  logic             in_invB,
    input  logic             in_sign,
    output logic [DW-1:0]    alu_A,
    output logic [DW-1:0]    alu_B,
    output logic             alu_Cin,
    output logic [2:0]       alu_Op,
    output logic             alu_invA,
    output logic             alu_invB,
    output logic             alu_sign,
    input  logic [DW-1:0]    alu_Out,
    input  logic             alu_Ofl,
    input  logic             alu_Z,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [DW-1:0]    res_Out,
    output logic             res_Ofl,
    output logic             res_Z,
    output logic [CNT_W-1:0] ofl_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             r_iss_valid;
    logic [DW-1:0]    r_A;
    logic [DW-1:0]    r_B;
    logic             r_Cin;
    logic [2:0]       r_Op;
    logic             r_invA;
    logic             r_invB;
    logic             r_sign;

    logic             r_res_valid;
    logic [DW-1:0]    r_res_Out;
    logic             r_res_Ofl;
    logic             r_res_Z;
    logic [CNT_W-1:0] r_ofl_cnt;

    logic             w_adv;
    logic             w_in_ready;
    logic             w_in_fire;
    logic             w_res_fire;

    // The issue slot drains into the result slot whenever that slot is empty or emptying.
    assign w_adv      = r_iss_valid & (~r_res_valid | res_ready);
    assign w_in_ready = ~r_iss_valid | w_adv;
    assign w_in_fire  = in_valid & w_in_ready;
    assign w_res_fire = r_res_valid & res_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_iss_valid <= 1'b0;
            r_A         <= '0;
            r_B         <= '0;
            r_Cin       <= 1'b0;
            r_Op        <= 3'b000;
            r_invA      <= 1'b0;
            r_invB      <= 1'b0;
            r_sign      <= 1'b0;
        end else if (w_in_fire) begin
            r_iss_valid <= 1'b1;
            r_A         <= in_A;
            r_B         <= in_B;
            r_Cin       <= in_Cin;
            r_Op        <= in_Op;
            r_invA      <= in_invA;
            r_invB      <= in_invB;
            r_sign      <= in_sign;
        end else if (w_adv) begin
            r_iss_valid <= 1'b0;
        end
    end

    // Capture of a new result takes priority over the downstream pop so that
    // a simultaneous drain and refill keeps res_valid high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_res_valid <= 1'b0;
            r_res_Out   <= '0;
            r_res_Ofl   <= 1'b0;
            r_res_Z     <= 1'b0;
        end else if (w_adv) begin
            r_res_valid <= 1'b1;
            r_res_Out   <= alu_Out;
            r_res_Ofl   <= alu_Ofl;
            r_res_Z     <= alu_Z;
        end else if (w_res_fire) begin
            r_res_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ofl_cnt <= '0;
        end else if (w_res_fire && r_res_Ofl && (r_ofl_cnt != CNT_MAX)) begin
            r_ofl_cnt <= r_ofl_cnt + 1'b1;
        end
    end

    assign in_ready  = w_in_ready;
    assign alu_A     = r_A;
    assign alu_B     = r_B;
    assign alu_Cin   = r_Cin;
    assign alu_Op    = r_Op;
    assign alu_invA  = r_invA;
    assign alu_invB  = r_invB;
    assign alu_sign  = r_sign;
    assign res_valid = r_res_valid;
    assign res_Out   = r_res_Out;
    assign res_Ofl   = r_res_Ofl;
    assign res_Z     = r_res_Z;
    assign ofl_cnt   = r_ofl_cnt;

endmodule

// File: tb/tb_alu_exec_pipe.sv
// Bench for alu_exec_pipe: a behavioural alu closes the loop, and a queue-based model of a
// two-deep in-order pipe predicts handshakes, results and overflow counts.
module tb_alu_exec_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [15:0] in_A, in_B;
    logic        in_Cin, in_invA, in_invB, in_sign;
    logic [2:0]  in_Op;
    logic        res_ready;

    logic        in_ready, res_valid, res_Ofl, res_Z;
    logic [15:0] res_Out;
    logic [7:0]  ofl_cnt;
    logic [15:0] alu_A, alu_B, alu_Out;
    logic        alu_Cin, alu_invA, alu_invB, alu_sign, alu_Ofl, alu_Z;
    logic [2:0]  alu_Op;

    logic        s_in_ready, s_res_valid, s_res_Ofl, s_res_Z;
    logic [15:0] s_res_Out;
    logic [1:0]  s_ofl_cnt;
    logic [15:0] s_alu_A, s_alu_B, s_alu_Out;
    logic        s_alu_Cin, s_alu_invA, s_alu_invB, s_alu_sign, s_alu_Ofl, s_alu_Z;
    logic [2:0]  s_alu_Op;

    always #5 clk = ~clk;

    // Behavioural alu: returns {Out, Ofl, Z}.
    function automatic logic [17:0] alu_ref(input logic [15:0] A, input logic [15:0] B,
                                            input logic cin, input logic [2:0] op,
                                            input logic ia, input logic ib, input logic sg);
        logic [15:0] a, b, o;
        logic [16:0] s;
        logic        of;
        a  = ia ? ~A : A;
        b  = ib ? ~B : B;
        of = 1'b0;
        s  = '0;
        case (op)
            3'd0: o = (a << b[3:0]) | (a >> (5'd16 - {1'b0, b[3:0]}));
            3'd1: o = a << b[3:0];
            3'd2: o = $unsigned($signed(a) >>> b[3:0]);
            3'd3: o = a >> b[3:0];
            3'd4: begin
                s  = {1'b0, a} + {1'b0, b} + {16'd0, cin};
                o  = s[15:0];
                of = sg ? ((a[15] == b[15]) && (o[15] != a[15])) : s[16];
            end
            3'd5: o = a | b;
            3'd6: o = a ^ b;
            default: o = a & b;
        endcase
        return {o, of, (o == 16'd0)};
    endfunction

    logic [17:0] w_r1, w_r2;
    always_comb w_r1 = alu_ref(alu_A, alu_B, alu_Cin, alu_Op, alu_invA, alu_invB, alu_sign);
    always_comb w_r2 = alu_ref(s_alu_A, s_alu_B, s_alu_Cin, s_alu_Op, s_alu_invA, s_alu_invB, s_alu_sign);
    assign alu_Out   = w_r1[17:2];
    assign alu_Ofl   = w_r1[1];
    assign alu_Z     = w_r1[0];
    assign s_alu_Out = w_r2[17:2];
    assign s_alu_Ofl = w_r2[1];
    assign s_alu_Z   = w_r2[0];

    alu_exec_pipe #(.DW(16), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_A(in_A), .in_B(in_B), .in_Cin(in_Cin), .in_Op(in_Op),
        .in_invA(in_invA), .in_invB(in_invB), .in_sign(in_sign),
        .alu_A(alu_A), .alu_B(alu_B), .alu_Cin(alu_Cin), .alu_Op(alu_Op),
        .alu_invA(alu_invA), .alu_invB(alu_invB), .alu_sign(alu_sign),
        .alu_Out(alu_Out), .alu_Ofl(alu_Ofl), .alu_Z(alu_Z),
        .res_valid(res_valid), .res_ready(res_ready), .res_Out(res_Out),
        .res_Ofl(res_Ofl), .res_Z(res_Z), .ofl_cnt(ofl_cnt)
    );

    alu_exec_pipe #(.DW(16), .CNT_W(2)) dut_s (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready),
        .in_A(in_A), .in_B(in_B), .in_Cin(in_Cin), .in_Op(in_Op),
        .in_invA(in_invA), .in_invB(in_invB), .in_sign(in_sign),
        .alu_A(s_alu_A), .alu_B(s_alu_B), .alu_Cin(s_alu_Cin), .alu_Op(s_alu_Op),
        .alu_invA(s_alu_invA), .alu_invB(s_alu_invB), .alu_sign(s_alu_sign),
        .alu_Out(s_alu_Out), .alu_Ofl(s_alu_Ofl), .alu_Z(s_alu_Z),
        .res_valid(s_res_valid), .res_ready(res_ready), .res_Out(s_res_Out),
        .res_Ofl(s_res_Ofl), .res_Z(s_res_Z), .ofl_cnt(s_ofl_cnt)
    );

    typedef struct {
        logic [15:0] o;
        logic        of;
        logic        z;
    } res_t;

    res_t        q[$];
    int          checks   = 0;
    int          failures = 0;
    int          cnt8     = 0;
    int          cnt2     = 0;
    logic        just_in  = 1'b0;
    logic        last_in_fire  = 1'b0;
    logic        last_res_fire = 1'b0;
    logic [15:0] last_res_o    = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_op(input logic [15:0] a, input logic [15:0] b, input logic cin,
                          input logic [2:0] op, input logic ia, input logic ib, input logic sg);
        in_A = a; in_B = b; in_Cin = cin; in_Op = op;
        in_invA = ia; in_invB = ib; in_sign = sg;
    endtask

    // One clock: check outputs at the falling edge, then advance the model at the rising edge.
    task automatic tick();
        logic        exp_ready, exp_rv, f_in, f_res;
        logic [17:0] r;
        res_t        e;
        @(negedge clk);
        exp_ready = (q.size() < 2) || res_ready;
        exp_rv    = (q.size() > 0) && !(q.size() == 1 && just_in);
        chk("in_ready", in_ready, exp_ready);
        chk("in_ready_s", s_in_ready, exp_ready);
        chk("res_valid", res_valid, exp_rv);
        chk("res_valid_s", s_res_valid, exp_rv);
        if (exp_rv) begin
            chk("res_Out", res_Out, q[0].o);
            chk("res_Ofl", res_Ofl, q[0].of);
            chk("res_Z", res_Z, q[0].z);
            chk("res_Out_s", s_res_Out, q[0].o);
            chk("res_Ofl_s", s_res_Ofl, q[0].of);
            chk("res_Z_s", s_res_Z, q[0].z);
        end
        chk("ofl_cnt", ofl_cnt, cnt8);
        chk("ofl_cnt_s", s_ofl_cnt, cnt2);
        f_in  = in_valid && exp_ready;
        f_res = exp_rv && res_ready;
        r     = alu_ref(in_A, in_B, in_Cin, in_Op, in_invA, in_invB, in_sign);
        @(posedge clk);
        if (f_res) begin
            e = q.pop_front();
            last_res_o = e.o;
            if (e.of) begin
                cnt8 = (cnt8 == 255) ? 255 : cnt8 + 1;
                cnt2 = (cnt2 == 3) ? 3 : cnt2 + 1;
            end
        end
        if (f_in) begin
            e.o = r[17:2]; e.of = r[1]; e.z = r[0];
            q.push_back(e);
        end
        just_in       = f_in;
        last_in_fire  = f_in;
        last_res_fire = f_res;
        #1;
    endtask

    initial begin
        int acc;
        int exp_cnt;
        rst = 1'b1; in_valid = 1'b0; res_ready = 1'b0;
        set_op(16'h0, 16'h0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
        #2;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_Out", res_Out, 0);
        chk("rst_res_flags", {res_Ofl, res_Z}, 0);
        chk("rst_ofl_cnt", ofl_cnt, 0);
        chk("rst_alu", {alu_A, alu_B, alu_Cin, alu_Op, alu_invA, alu_invB, alu_sign}, 0);
        @(posedge clk); #1; rst = 1'b0;

        // Single add
        res_ready = 1'b1;
        set_op(16'h1234, 16'h0001, 1'b0, 3'd4, 1'b0, 1'b0, 1'b0);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("add_alu_A", alu_A, 16'h1234);
        chk("add_alu_Op", alu_Op, 3'd4);
        chk("add_res_valid_early", res_valid, 0);
        tick();
        chk("add_res_valid", res_valid, 1);
        chk("add_res_Out", res_Out, 16'h1235);
        chk("add_res_flags", {res_Ofl, res_Z}, 2'b00);
        tick();

        // Signed overflow and count
        set_op(16'h7FFF, 16'h0001, 1'b0, 3'd4, 1'b0, 1'b0, 1'b1);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        chk("ofl_res_Out", res_Out, 16'h8000);
        chk("ofl_res_Ofl", res_Ofl, 1);
        chk("ofl_cnt_before", ofl_cnt, 0);
        tick();
        chk("ofl_cnt_after", ofl_cnt, 1);

        // Zero flag
        set_op(16'hA5A5, 16'hA5A5, 1'b0, 3'd6, 1'b0, 1'b0, 1'b0);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        chk("xor_res_Out", res_Out, 16'h0000);
        chk("xor_res_Z", res_Z, 1);
        tick();

        // Back-pressure: four ops against a stalled consumer
        res_ready = 1'b0;
        acc = 0;
        for (int c = 0; c < 6; c++) begin
            if (acc < 4) begin
                set_op(16'h0100 * 16'(acc + 1), 16'h0001, 1'b0, 3'd4, 1'b0, 1'b0, 1'b0);
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            tick();
            if (last_in_fire) acc++;
        end
        chk("bp_accepted", acc, 2);
        chk("bp_in_ready", in_ready, 0);
        chk("bp_res_Out_held", res_Out, 16'h0101);
        res_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            if (acc < 4) begin
                set_op(16'h0100 * 16'(acc + 1), 16'h0001, 1'b0, 3'd4, 1'b0, 1'b0, 1'b0);
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            tick();
            if (last_in_fire) acc++;
            chk("bp_drain_fire", last_res_fire, 1);
            chk("bp_drain_order", last_res_o, 16'h0100 * 16'(c + 1) + 16'h0001);
        end
        in_valid = 1'b0;
        tick();
        chk("bp_empty", res_valid, 0);

        // Saturation: five more overflowing results
        in_valid = 1'b1;
        set_op(16'h4000, 16'h4000, 1'b0, 3'd4, 1'b0, 1'b0, 1'b1);
        for (int c = 0; c < 5; c++) tick();
        in_valid = 1'b0;
        for (int c = 0; c < 3; c++) tick();
        chk("sat_cnt2", s_ofl_cnt, 2'd3);
        chk("sat_cnt8", ofl_cnt, 8'd6);

        // Reset with both slots full
        res_ready = 1'b0;
        in_valid  = 1'b1;
        set_op(16'hBEEF, 16'h0001, 1'b1, 3'd4, 1'b0, 1'b0, 1'b0);
        for (int c = 0; c < 3; c++) tick();
        chk("prerst_full", in_ready, 0);
        #1 rst = 1'b1;
        #1;
        chk("midrst_res_valid", res_valid, 0);
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_ofl_cnt", {ofl_cnt, s_ofl_cnt}, 0);
        chk("midrst_alu_A", alu_A, 0);
        q.delete();
        cnt8 = 0; cnt2 = 0; just_in = 1'b0;
        in_valid = 1'b0;
        @(posedge clk); #1; rst = 1'b0;
        res_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("postrst_no_ghost", last_res_fire | res_valid, 0);
        end

        // Randomized traffic
        for (int c = 0; c < 400; c++) begin
            in_valid  = ($urandom % 4) != 0;
            res_ready = ($urandom % 3) != 0;
            set_op(16'($urandom), 16'($urandom), 1'($urandom), 3'($urandom),
                   1'($urandom), 1'($urandom), 1'($urandom));
            if (($urandom % 8) == 0) in_B = 16'h0001;
            tick();
        end
        in_valid  = 1'b0;
        res_ready = 1'b1;
        for (int c = 0; c < 4; c++) tick();
        chk("drain_model_empty", q.size(), 0);
        chk("drain_res_valid", res_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
